// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared lane count, select width and lane index constants
package demux_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  // Lane indices match the op encoding used by mux32_8
  localparam logic [SEL_W-1:0] LANE_A = 3'd0;
  localparam logic [SEL_W-1:0] LANE_B = 3'd1;
  localparam logic [SEL_W-1:0] LANE_C = 3'd2;
  localparam logic [SEL_W-1:0] LANE_D = 3'd3;
  localparam logic [SEL_W-1:0] LANE_E = 3'd4;
  localparam logic [SEL_W-1:0] LANE_F = 3'd5;
  localparam logic [SEL_W-1:0] LANE_G = 3'd6;
  localparam logic [SEL_W-1:0] LANE_H = 3'd7;
endpackage

// File: rtl/demux32_8_reg_if.sv
// rtl/demux32_8_reg_if.sv - input handshake and per-lane output bundle
interface demux32_8_reg_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_op;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES-1:0]       out_ack;

  modport master (
    output in_data, in_op, in_valid, out_ack,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_op, in_valid, out_ack,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_lane.sv
// rtl/demux_lane.sv - one-word holding register with valid flag and ack drain
module demux_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             free
);
  // An acked lane can be refilled in the same cycle
  assign free = ~valid | ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux32_8_reg.sv
// rtl/demux32_8_reg.sv - registered 1-to-8 word distributor with per-lane ack
module demux32_8_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  demux32_8_reg_if.slave    bus,
  output logic [CNT_W-1:0]  accept_cnt,
  output logic              busy
);
  logic [LANES-1:0]       free;
  logic [LANES-1:0]       load;
  logic [LANES-1:0]       valid;
  logic [LANES*WIDTH-1:0] q_all;
  logic                   accept;

  assign bus.in_ready = free[bus.in_op];
  assign accept       = bus.in_valid & bus.in_ready;
  assign load         = accept ? (LANES'(1) << bus.in_op) : '0;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .ack   (bus.out_ack[k]),
      .d     (bus.in_data),
      .q     (q_all[k*WIDTH +: WIDTH]),
      .valid (valid[k]),
      .free  (free[k])
    );
  end

  assign bus.out_data  = q_all;
  assign bus.out_valid = valid;
  assign busy          = |valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt <= '0;
    end else if (accept) begin
      accept_cnt <= accept_cnt + CNT_W'(1);
    end
  end
endmodule
